aes_round_iter: RTL and testbench
=================================

AES_ROUND_ITER -- requirements
Module: aes_round_iter

Interface
REQ-001 SHALL expose `clk`, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL expose `reset`, input, 1, asynchronous and active-high.
REQ-003 SHALL expose `start`, input, 1, a request to begin one block operation; sampled only when `busy`=0.
REQ-004 SHALL expose `din`, input, 128, the input block; sampled on the accepting edge only.
REQ-005 SHALL expose `round_idx`, output, 4, the index of the round key currently requested.
REQ-006 SHALL expose `round_key`, input, 128, the round key for `round_idx`; combinational from the external key schedule, valid in the same cycle.
REQ-007 SHALL expose `busy`, output, 1, high while a block is in flight.
REQ-008 SHALL expose `done`, output, 1, a single-cycle pulse marking `dout` newly valid.
REQ-009 SHALL expose `dout`, output, 128, the result block; held until the next `done`.
REQ-010 SHALL use AES state byte 0 = bits [127:120], column-major: column c = bytes 4c..4c+3, matching the existing MixColumns/InvMixColumns.

Function
REQ-011 SHALL implement states IDLE, ROUND, FINAL; transitions are IDLE->ROUND on accept, ROUND->ROUND while the count < 9, ROUND->FINAL after the 9th round, FINAL->IDLE.
REQ-012 SHALL drive `round_idx`=0 in IDLE; on the accepting edge E0, state_reg <= `din` XOR `round_key`, and `round_idx` becomes 1.
REQ-013 SHALL, on each ROUND edge E1..E9 (encrypt), compute state_reg <= MixColumns(ShiftRows(SubBytes(state_reg))) XOR `round_key`, then increment `round_idx`.
REQ-014 SHALL instantiate the existing MixColumns for the round datapath; SubBytes and ShiftRows are purely combinational.
REQ-015 SHALL, on the FINAL edge E10, load `dout` <= ShiftRows(SubBytes(state_reg)) XOR `round_key` (key 10), with no MixColumns.
REQ-016 SHALL assert `done`=1 for exactly the one cycle following E10; latency from the accepting edge to `done` high is 10 cycles.
REQ-017 SHALL hold `busy`=1 from after E0 through E10 inclusive, and drop it in the same cycle that `done` rises.
REQ-018 SHALL ignore `start` while `busy`=1, with no effect on state, `round_idx` or `dout`.
REQ-019 SHALL accept `start` in the `done` cycle, giving back-to-back operation with no bubble.
REQ-020 SHALL reset `round_idx` to 0 when returning to IDLE.

Reset
REQ-021 SHALL, while `reset`=1 and asynchronously, force IDLE, `round_idx`=0, `busy`=0, `done`=0, `dout`=0 and state_reg=0.
REQ-022 SHALL, on reset mid-operation, abort the block with no `done` and leave `dout`=0.
REQ-023 SHALL accept `start` on the first rising edge after `reset` deasserts.

Configuration
REQ-024 SHALL, when macro AES_DECRYPT_EN is defined, add input port `decrypt` (1 bit), sampled on the accepting edge.
REQ-025 SHALL, with `decrypt`=1, run the inverse cipher:
- `round_idx` counts 10 down to 0, starting at 10 in IDLE.
- ROUND edges: InvMixColumns(InvSubBytes(InvShiftRows(s)) XOR key).
- FINAL edge: InvSubBytes(InvShiftRows(s)) XOR key 0.
- Latency is identical to encrypt.
REQ-026 SHALL, when AES_DECRYPT_EN is undefined, omit the `decrypt` port, the inverse datapath and the existing InvMixColumns instance; encrypt only, with `round_idx`=0 in IDLE.

Verification
REQ-027 SHALL check: reset, then start with `din`=00112233445566778899aabbccddeeff and the bench key schedule for key 000102030405060708090a0b0c0d0e0f -> `done` exactly 10 cycles later, `dout`=69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-028 SHALL check: start pulsed on every cycle while `busy`=1 -> exactly one `done`, with `dout` unchanged from the REQ-027 result.
REQ-029 SHALL check: `reset` asserted at cycle 5 of an operation -> `busy`, `done`, `dout` and `round_idx` read 0 immediately; no `done` appears afterwards.
REQ-030 SHALL check: two blocks back-to-back, the second start in the `done` cycle -> `done` pulses 10 cycles apart, each `dout` correct.
REQ-031 SHALL check (AES_DECRYPT_EN): `decrypt`=1, `din`=69c4e0d86a7b0430d8cdb78070b4c55a, same key -> `dout`=00112233445566778899aabbccddeeff and `round_idx` sequence 10..0.

Source files
------------

// File: rtl/aes_round_iter.sv
// aes_round_iter: iterative AES-128 cipher core, one round per clock.
// The key schedule lives outside; round_idx selects the key returned on round_key
// combinationally in the same cycle. State byte 0 is bits [127:120], column-major.
// Optional macro AES_DECRYPT_EN adds the `decrypt` port and the inverse datapath.

// One 32-bit MixColumns (INV=0) or InvMixColumns (INV=1) column; row 0 is the MSB byte.
module mixColumn #(
    parameter bit INV = 1'b0
) (
    input  logic [31:0] colIn,
    output logic [31:0] colOut
);
    logic [0:3][7:0] a, y;

    // GF(2^8) multiply by a small constant (k < 16) using repeated xtime
    function automatic logic [7:0] gmulC(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] p, t;
        p = 8'h00;
        t = b;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // circulant matrix first row; each output row rotates it by one byte
    localparam logic [0:3][3:0] COEF = INV ? {4'd14, 4'd11, 4'd13, 4'd9}
                                           : {4'd2, 4'd3, 4'd1, 4'd1};

    assign a      = colIn;
    assign colOut = y;

    for (genvar r = 0; r < 4; r++) begin : gRow
        assign y[r] = gmulC(a[r], COEF[0]) ^ gmulC(a[(r+1)%4], COEF[1])
                    ^ gmulC(a[(r+2)%4], COEF[2]) ^ gmulC(a[(r+3)%4], COEF[3]);
    end
endmodule

module aes_round_iter (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] din,
`ifdef AES_DECRYPT_EN
    input  logic         decrypt,
`endif
    input  logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         busy,
    output logic         done,
    output logic [127:0] dout
);
    typedef logic [0:15][7:0] blockT;
    typedef enum logic [1:0] {IDLE, ROUND, FINAL} fsmT;

    fsmT        fsm, fsmNext;
    blockT      st, stNext;
    logic [3:0] idxReg, idxNext;
    logic [127:0] doutNext;
    logic       doneNext;

    blockT      key, subOut, shrOut, mixOut, roundNext, finalNext;
    logic [3:0] idxStep, idleIdx, idxFirst;
    logic       lastRound;

    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // multiplicative inverse as x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0
    function automatic logic [7:0] gfInv(input logic [7:0] x);
        logic [7:0] r, p;
        r = 8'h01;
        p = x;
        for (int i = 1; i < 8; i++) begin
            p = gfMul(p, p);
            r = gfMul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] i;
        i = gfInv(x);
        return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
    endfunction

    assign key = round_key;

    // forward round: SubBytes -> ShiftRows -> MixColumns
    for (genvar b = 0; b < 16; b++) begin : gSub
        assign subOut[b] = sbox(st[b]);
    end
    for (genvar c = 0; c < 4; c++) begin : gCol
        for (genvar r = 0; r < 4; r++) begin : gShr
            assign shrOut[4*c+r] = subOut[4*((c+r)%4)+r];
        end
        mixColumn #(.INV(1'b0)) uMix (
            .colIn (shrOut[4*c +: 4]),
            .colOut(mixOut[4*c +: 4])
        );
    end

`ifdef AES_DECRYPT_EN
    blockT invShr, invSub, invAdd, invMix;
    logic  decReg;

    function automatic logic [7:0] invSbox(input logic [7:0] x);
        return gfInv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
    endfunction

    // inverse round: InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns
    for (genvar c = 0; c < 4; c++) begin : gInvCol
        for (genvar r = 0; r < 4; r++) begin : gInvShr
            assign invShr[4*c+r] = st[4*((c-r+4)%4)+r];
            assign invSub[4*c+r] = invSbox(invShr[4*c+r]);
        end
        mixColumn #(.INV(1'b1)) uInvMix (
            .colIn (invAdd[4*c +: 4]),
            .colOut(invMix[4*c +: 4])
        );
    end
    assign invAdd = invSub ^ key;

    // direction is latched on the accepting edge and held for the whole block
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                     decReg <= 1'b0;
        else if (fsm == IDLE && start) decReg <= decrypt;
    end

    assign roundNext = decReg ? invMix : (mixOut ^ key);
    assign finalNext = decReg ? invAdd : (shrOut ^ key);
    assign lastRound = decReg ? (idxReg == 4'd1) : (idxReg == 4'd9);
    assign idxStep   = decReg ? idxReg - 4'd1 : idxReg + 4'd1;
    assign idxFirst  = decrypt ? 4'd9 : 4'd1;
    // idle index follows the direction request so key 10 is ready for a decrypt accept
    assign idleIdx   = (decrypt && !reset) ? 4'd10 : 4'd0;
`else
    assign roundNext = mixOut ^ key;
    assign finalNext = shrOut ^ key;
    assign lastRound = (idxReg == 4'd9);
    assign idxStep   = idxReg + 4'd1;
    assign idxFirst  = 4'd1;
    assign idleIdx   = 4'd0;
`endif

    assign round_idx = (fsm == IDLE) ? idleIdx : idxReg;
    assign busy      = (fsm != IDLE);

    // next-state and datapath selection
    always_comb begin
        fsmNext  = fsm;
        stNext   = st;
        idxNext  = idxReg;
        doutNext = dout;
        doneNext = 1'b0;
        case (fsm)
            IDLE: begin
                if (start) begin
                    fsmNext = ROUND;
                    stNext  = din ^ round_key;
                    idxNext = idxFirst;
                end
            end
            ROUND: begin
                stNext  = roundNext;
                idxNext = idxStep;
                if (lastRound) fsmNext = FINAL;
            end
            FINAL: begin
                doutNext = finalNext;
                doneNext = 1'b1;
                idxNext  = 4'd0;
                fsmNext  = IDLE;
            end
            default: fsmNext = IDLE;
        endcase
    end

    // state, round counter and result registers; reset aborts any block in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm    <= IDLE;
            st     <= '0;
            idxReg <= 4'd0;
            dout   <= '0;
            done   <= 1'b0;
        end else begin
            fsm    <= fsmNext;
            st     <= stNext;
            idxReg <= idxNext;
            dout   <= doutNext;
            done   <= doneNext;
        end
    end
endmodule

// File: tb/tb_aes_round_iter.sv
// tb_aes_round_iter: randomized bench for aes_round_iter against a byte-level AES model.
// Define AES_DECRYPT_EN on both bench and RTL to cover the inverse cipher.
module tb_aes_round_iter;
    localparam logic [127:0] KAT_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KAT_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         reset, start, busy, done;
    logic [127:0] din, round_key, dout;
    logic [3:0]   round_idx;
`ifdef AES_DECRYPT_EN
    logic         decrypt;
`endif

    int checks = 0, failures = 0;
    logic [7:0]   sb[256], isb[256];
    logic [127:0] rk[11];

    always #5 clk = ~clk;

    // external key schedule: combinational lookup on the requested index
    assign round_key = (round_idx <= 4'd10) ? rk[round_idx] : '0;

    aes_round_iter dut (
        .clk(clk), .reset(reset), .start(start), .din(din),
`ifdef AES_DECRYPT_EN
        .decrypt(decrypt),
`endif
        .round_key(round_key), .round_idx(round_idx),
        .busy(busy), .done(done), .dout(dout)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, t;
        p = 0; t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= t;
            t = xtime(t);
        end
        return p;
    endfunction

    // S-box tables by brute-force inverse search plus the bitwise affine definition
    task automatic buildSbox();
        logic [7:0] inv, s, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 0;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sb[x]  = s;
            isb[s] = 8'(x);
        end
    endtask

    task automatic setKey(input logic [127:0] k);
        logic [31:0] w[44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] subBytes(input logic [127:0] x, input bit inv);
        logic [127:0] y;
        for (int i = 0; i < 16; i++)
            y[127-8*i -: 8] = inv ? isb[x[127-8*i -: 8]] : sb[x[127-8*i -: 8]];
        return y;
    endfunction

    function automatic logic [127:0] shiftRows(input logic [127:0] x, input bit inv);
        logic [127:0] y;
        int src;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                src = inv ? (c - r + 4) % 4 : (c + r) % 4;
                y[127-8*(4*c+r) -: 8] = x[127-8*(4*src+r) -: 8];
            end
        return y;
    endfunction

    function automatic logic [7:0] mcCoef(input int d, input bit inv);
        case (d)
            0:       return inv ? 8'd14 : 8'd2;
            1:       return inv ? 8'd11 : 8'd3;
            2:       return inv ? 8'd13 : 8'd1;
            default: return inv ? 8'd9  : 8'd1;
        endcase
    endfunction

    function automatic logic [127:0] mixCols(input logic [127:0] x, input bit inv);
        logic [127:0] y;
        logic [7:0]   v;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                v = 0;
                for (int k = 0; k < 4; k++)
                    v ^= gmul(x[127-8*(4*c+k) -: 8], mcCoef((k - r + 4) % 4, inv));
                y[127-8*(4*c+r) -: 8] = v;
            end
        return y;
    endfunction

    function automatic logic [127:0] aesEnc(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rk[0];
        for (int r = 1; r < 10; r++) s = mixCols(shiftRows(subBytes(s, 0), 0), 0) ^ rk[r];
        return shiftRows(subBytes(s, 0), 0) ^ rk[10];
    endfunction

    function automatic logic [127:0] aesDec(input logic [127:0] ct);
        logic [127:0] s;
        s = ct ^ rk[10];
        for (int r = 9; r >= 1; r--) s = mixCols(subBytes(shiftRows(s, 1), 1) ^ rk[r], 1);
        return subBytes(shiftRows(s, 1), 1) ^ rk[0];
    endfunction

    function automatic logic [127:0] randBlock();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- stimulus helpers ----------------
    // Caller raises start/din just before the accepting edge. Returns at the done
    // sample (#1 after the edge), with latency in cycles and the round_idx trace.
    task automatic waitOp(output logic [127:0] got, output int lat, output logic [47:0] seq);
        bit busyOk;
        busyOk = 1;
        seq = {44'h0, round_idx};
        lat = -1;
        @(posedge clk); #1;
        start = 0;
        seq = {seq[43:0], round_idx};
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            seq = {seq[43:0], round_idx};
            if (done) begin lat = n; break; end
            if (!busy) busyOk = 0;
        end
        got = dout;
        chk("busy_inflight", 128'(busyOk), 128'd1);
        chk("busy_at_done", 128'(busy), 128'd0);
    endtask

    initial begin
        logic [127:0] got, got2, pt, ct;
        logic [47:0]  seq;
        int lat, lat2, doneCnt;

        reset = 1; start = 0; din = '0;
`ifdef AES_DECRYPT_EN
        decrypt = 0;
`endif
        buildSbox();
        setKey(KAT_KEY);
        #12;
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_dout", dout, 128'd0);
        chk("rst_idx", 128'(round_idx), 128'd0);

        // known answer, started on the first edge after reset release
        @(negedge clk); reset = 0; start = 1; din = KAT_PT;
        waitOp(got, lat, seq);
        chk("kat_dout", got, KAT_CT);
        chk("kat_latency", 128'(lat), 128'd10);
        chk("kat_idx_seq", 128'(seq), 128'h0123456789A0);
        @(posedge clk); #1;
        chk("done_single", 128'(done), 128'd0);
        chk("dout_hold", dout, KAT_CT);

        // start hammered while busy: exactly one done, result unaffected
        @(negedge clk); start = 1; din = KAT_PT;
        @(posedge clk); #1;
        doneCnt = 0; lat = -1; got = '0;
        for (int n = 1; n <= 25; n++) begin
            din = randBlock();
            start = (lat < 0);
            @(posedge clk); #1;
            if (done) begin
                doneCnt++;
                if (lat < 0) begin lat = n; start = 0; got = dout; end
            end
        end
        start = 0;
        chk("ign_done_count", 128'(doneCnt), 128'd1);
        chk("ign_latency", 128'(lat), 128'd10);
        chk("ign_dout", got, KAT_CT);
        chk("ign_dout_after", dout, KAT_CT);

        // random keys and blocks
        for (int t = 0; t < 6; t++) begin
            setKey(randBlock());
            pt = randBlock();
            @(negedge clk); start = 1; din = pt;
            waitOp(got, lat, seq);
            chk("rnd_dout", got, aesEnc(pt));
            chk("rnd_latency", 128'(lat), 128'd10);
        end

        // back-to-back: second start presented in the done cycle
        setKey(randBlock());
        pt = randBlock();
        ct = randBlock();
        @(negedge clk); start = 1; din = pt;
        waitOp(got, lat, seq);
        start = 1; din = ct;
        waitOp(got2, lat2, seq);
        chk("b2b_dout0", got, aesEnc(pt));
        chk("b2b_dout1", got2, aesEnc(ct));
        chk("b2b_spacing", 128'(lat2), 128'd10);

        // reset in cycle 5 of a block: outputs clear at once, no done later
        @(negedge clk); start = 1; din = randBlock();
        @(posedge clk); #1; start = 0;
        repeat (4) @(posedge clk);
        #1; reset = 1; #1;
        chk("abort_busy", 128'(busy), 128'd0);
        chk("abort_done", 128'(done), 128'd0);
        chk("abort_dout", dout, 128'd0);
        chk("abort_idx", 128'(round_idx), 128'd0);
        @(negedge clk); reset = 0;
        doneCnt = 0;
        repeat (15) begin @(posedge clk); #1; if (done) doneCnt++; end
        chk("abort_no_done", 128'(doneCnt), 128'd0);
        chk("abort_dout_after", dout, 128'd0);

`ifdef AES_DECRYPT_EN
        // inverse cipher known answer with the round index counting down
        setKey(KAT_KEY);
        @(negedge clk); decrypt = 1; start = 1; din = KAT_CT;
        #1;
        chk("dec_idle_idx", 128'(round_idx), 128'd10);
        waitOp(got, lat, seq);
        chk("dec_dout", got, KAT_PT);
        chk("dec_latency", 128'(lat), 128'd10);
        chk("dec_idx_seq", 128'(seq), 128'hA9876543210A);
        for (int t = 0; t < 3; t++) begin
            setKey(randBlock());
            ct = randBlock();
            @(negedge clk); decrypt = 1; start = 1; din = ct;
            waitOp(got, lat, seq);
            chk("dec_rnd_dout", got, aesDec(ct));
        end
        // encrypt again after decrypt to confirm the direction is re-sampled
        pt = randBlock();
        @(negedge clk); decrypt = 0; start = 1; din = pt;
        waitOp(got, lat, seq);
        chk("enc_after_dec", got, aesEnc(pt));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
